// File: rtl/avmm_burst_mem_responder.sv
// Avalon-MM burst responder backed by a local RAM.
// It is the host-memory end of the kernel's wide master. Burst writes are
// committed into the RAM. Burst reads are queued in a small command FIFO and
// issued one beat per cycle. Each beat returns a fixed READ_LATENCY cycles
// after it is issued.
//
// Ports:
//   clk_clk            single clock
//   reset_reset        asynchronous active-high reset
//   avs_address        byte address; the word index is address[MEM_WORDS_LOG2+5:6]
//   avs_read           read command
//   avs_write          write beat
//   avs_writedata      write data
//   avs_byteenable     per-byte write enable
//   avs_burstcount     burst length (0 is treated as 1), sampled on the first beat
//   avs_waitrequest    back-pressure
//   avs_readdata       read data
//   avs_readdatavalid  read data qualifier
module avmm_burst_mem_responder #(
    parameter int DATA_W         = 512,
    parameter int ADDR_W         = 48,
    parameter int BURST_W        = 4,
    parameter int MEM_WORDS_LOG2 = 10,
    parameter int READ_LATENCY   = 2,
    parameter int MAX_PENDING    = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [ADDR_W-1:0]     avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [DATA_W-1:0]     avs_writedata,
    input  logic [DATA_W/8-1:0]   avs_byteenable,
    input  logic [BURST_W-1:0]    avs_burstcount,
    output logic                  avs_waitrequest,
    output logic [DATA_W-1:0]     avs_readdata,
    output logic                  avs_readdatavalid
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = MEM_WORDS_LOG2;
    localparam int DEPTH = 1 << MEM_WORDS_LOG2;
    localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1);
    localparam logic [IDX_W-1:0]   ONE_I = IDX_W'(1);
    localparam logic [CNT_W-1:0]   ONE_C = CNT_W'(1);

    typedef enum logic [0:0] {IDLE, WBURST} wstate_t;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_PENDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [DATA_W-1:0]  mem [DEPTH];

    wstate_t            state, state_nxt;
    logic               ready;
    logic [IDX_W-1:0]   wr_idx;
    logic [BURST_W-1:0] wr_rem;
    logic               rd_acc, wr_acc, wait_c;

    logic [IDX_W-1:0]   fifo_idx [MAX_PENDING];
    logic [BURST_W-1:0] fifo_len [MAX_PENDING];
    logic [PTR_W-1:0]   f_wp, f_rp;
    logic [CNT_W-1:0]   f_cnt;
    logic               fifo_full, fifo_empty;

    logic [BURST_W-1:0] beat_off;
    logic               issue_vld_p0, issue_last;
    logic [IDX_W-1:0]   issue_idx_p0;

    logic [READ_LATENCY-1:0] vld_p;
    logic [DATA_W-1:0]       data_p [READ_LATENCY];

    logic [IDX_W-1:0]   addr_idx, wr_word;
    logic [BURST_W-1:0] len_m1;
    logic               reads_pending;
    logic               unused_addr;

    assign addr_idx    = avs_address[IDX_W+5:6];
    assign unused_addr = ^{avs_address[ADDR_W-1:IDX_W+6], avs_address[5:0]};
    // The stored length is the burst length minus one, so a burstcount of 0 becomes a single beat.
    assign len_m1      = (avs_burstcount == '0) ? '0 : avs_burstcount - ONE_B;
    assign wr_word     = (state == IDLE) ? addr_idx : wr_idx;

    assign fifo_full     = (f_cnt == CNT_W'(MAX_PENDING));
    assign fifo_empty    = (f_cnt == '0);
    // A write may start only when every accepted read has fully drained.
    assign reads_pending = !fifo_empty || (|vld_p);

    // The head command stays in the FIFO while it is being issued. It is popped
    // on its last beat, so the next head issues on the following cycle without a bubble.
    assign issue_vld_p0 = !fifo_empty;
    assign issue_idx_p0 = fifo_idx[f_rp] + IDX_W'(beat_off);
    assign issue_last   = issue_vld_p0 && (beat_off == fifo_len[f_rp]);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            ready  <= 1'b0;
            state  <= IDLE;
            wr_idx <= '0;
            wr_rem <= '0;
        end else begin
            ready <= 1'b1;
            state <= state_nxt;
            if (wr_acc) begin
                wr_idx <= wr_word + ONE_I;
                wr_rem <= (state == IDLE) ? len_m1 : wr_rem - ONE_B;
            end
        end
    end

    // When read and write are both asserted, the read wins. During a write burst, reads are refused.
    always_comb begin
        state_nxt = state;
        wait_c    = 1'b1;
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        if (ready) begin
            case (state)
                IDLE: begin
                    if (avs_read) begin
                        if (!fifo_full) begin
                            wait_c = 1'b0;
                            rd_acc = 1'b1;
                        end
                    end else if (avs_write) begin
                        if (!reads_pending) begin
                            wait_c = 1'b0;
                            wr_acc = 1'b1;
                            if (len_m1 != '0) state_nxt = WBURST;
                        end
                    end else begin
                        wait_c = 1'b0;
                    end
                end
                WBURST: begin
                    if (!avs_read) begin
                        wait_c = 1'b0;
                        if (avs_write) begin
                            wr_acc = 1'b1;
                            if (wr_rem == ONE_B) state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (wr_acc) begin
            for (int b = 0; b < BE_W; b++) begin
                if (avs_byteenable[b]) mem[wr_word][b*8 +: 8] <= avs_writedata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (rd_acc) begin
            fifo_idx[f_wp] <= addr_idx;
            fifo_len[f_wp] <= len_m1;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            f_wp     <= '0;
            f_rp     <= '0;
            f_cnt    <= '0;
            beat_off <= '0;
        end else begin
            if (rd_acc) f_wp <= next_ptr(f_wp);
            if (issue_last) f_rp <= next_ptr(f_rp);
            case ({rd_acc, issue_last})
                2'b10:   f_cnt <= f_cnt + ONE_C;
                2'b01:   f_cnt <= f_cnt - ONE_C;
                default: f_cnt <= f_cnt;
            endcase
            if (issue_vld_p0) beat_off <= issue_last ? '0 : beat_off + ONE_B;
        end
    end

    // p0 -> p1..pN: RAM read, then a delay line that gives exactly READ_LATENCY cycles
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            vld_p <= '0;
            for (int j = 0; j < READ_LATENCY; j++) data_p[j] <= '0;
        end else begin
            vld_p[0]  <= issue_vld_p0;
            data_p[0] <= mem[issue_idx_p0];
            for (int j = 1; j < READ_LATENCY; j++) begin
                vld_p[j]  <= vld_p[j-1];
                data_p[j] <= data_p[j-1];
            end
        end
    end

    assign avs_waitrequest   = wait_c;
    assign avs_readdatavalid = vld_p[READ_LATENCY-1];
    assign avs_readdata      = data_p[READ_LATENCY-1];

endmodule

// File: doc/avmm_burst_mem_responder.md
Name: avmm_burst_mem_responder

Overview:
- Avalon-MM burst responder (slave) for the 512-bit expanded master of the accelerator shell.
- Acts as the host-memory end of the protocol: accepts burst writes into a local RAM and serves pipelined burst reads with fixed latency.
- Used as the simulation and bring-up memory behind the kernel's 48-bit master.

Parameters:
- DATA_W, 512, data bus width in bits; byteenable width = DATA_W/8.
- ADDR_W, 48, byte address width.
- BURST_W, 4, burstcount width; maximum burst is 2^BURST_W-1 = 15 beats.
- MEM_WORDS_LOG2, 10, local RAM depth = 2^MEM_WORDS_LOG2 words of DATA_W bits.
- READ_LATENCY, 2, cycles from read-beat issue to readdatavalid; legal range 1..4.
- MAX_PENDING, 4, depth of the accepted-read-command FIFO.

Ports:
- clk_clk  in  1  single clock.
- reset_reset  in  1  asynchronous, active-high reset.
- avs_address  in  ADDR_W  byte address; word index = address[MEM_WORDS_LOG2+5:6]; upper bits are ignored, so addresses alias modulo the RAM depth.
- avs_read  in  1  read command.
- avs_write  in  1  write beat.
- avs_writedata  in  DATA_W  write data.
- avs_byteenable  in  DATA_W/8  per-byte write enable; ignored for reads.
- avs_burstcount  in  BURST_W  beats in the burst; sampled on the first beat only.
- avs_waitrequest  out  1  back-pressure.
- avs_readdata  out  DATA_W  read data.
- avs_readdatavalid  out  1  read data qualifier.

Behaviour:
- Reset:
  - All outputs reset as follows: waitrequest=1, readdatavalid=0, readdata=0.
  - FSM to IDLE; command FIFO and latency pipe flushed.
  - RAM contents are not reset.
  - Reset mid-burst abandons the burst; no further readdatavalid is emitted.
- waitrequest deasserts on the first clk_clk edge after reset_reset falls.
- Transfer: a cycle transfers when (read|write) && !waitrequest.
- burstcount=0 is treated as 1.
- Write FSM (IDLE, WBURST):
  - IDLE: a first write beat is accepted only when no reads are pending (FIFO empty, issue engine idle, latency pipe empty); otherwise waitrequest=1.
  - On acceptance: write the beat to base word; latch base+1 and remaining=burstcount-1; go to WBURST if remaining>0, else stay in IDLE.
  - WBURST: each accepted write beat writes the next word (index wraps modulo depth) and decrements remaining. Return to IDLE when remaining reaches 0.
  - While in WBURST, avs_read is refused (waitrequest=1).
- Byteenable: only enabled bytes are updated; all-zero byteenable is a legal no-op beat that still counts toward the burst.
- Read accept:
  - Allowed in IDLE when the FIFO is not full; push {word index, burstcount}.
  - Reads may be accepted back-to-back while earlier bursts are still returning.
  - waitrequest=1 when the FIFO is full.
- Read issue engine:
  - Pops the FIFO head and issues one beat per cycle, incrementing the word index with wrap.
  - Pops the next entry on the cycle after the last beat; there are no bubbles between consecutive bursts.
- Latency: each issued beat produces readdatavalid=1 exactly READ_LATENCY cycles later. Beats return in order, contiguously within a burst.
- Simultaneous read and write in one cycle (protocol violation): the read is serviced and the write beat is refused (waitrequest=1 for that cycle).
- Hazard ordering: reads never observe a partially committed write burst, and a write never overtakes an accepted read.

Test Plan:
- Single write then read: write addr 0x40, data 0xA5 pattern, byteenable all-ones, burstcount 1; read addr 0x40, burstcount 1 -> readdatavalid exactly 2 cycles after issue, readdata equals 0xA5 pattern.
- Burst write/read: 8-beat write at 0x1000 with data = beat index; 8-beat read -> 8 contiguous readdatavalid pulses returning 0..7 in order.
- Byteenable merge: write all-ones to word 5, then write zero with byteenable=0x...000F -> read returns low 4 bytes zero, remaining bytes all-ones.
- Back-pressure: issue 5 back-to-back 15-beat reads -> waitrequest asserted on the 5th command until the first burst is popped; 75 total beats return in command order.
- Wrap and alias: with MEM_WORDS_LOG2=10, a 4-beat write at word 1022 hits words 1022, 1023, 0, 1; a read at byte address 0x10000 (word 1024) returns word 0's data.
- Reset mid-read: assert reset_reset during beat 3 of an 8-beat read -> readdatavalid=0 immediately and waitrequest=1; after release, a new read returns correct data with no stale beats.
